// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state, side and leg encodings for the airlock scheduler.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_OPEN_OUT,
    ST_OPEN_IN
  } state_t;

  localparam logic SIDE_SEA   = 1'b0;
  localparam logic SIDE_DOCK  = 1'b1;

  localparam logic LEG_FIRST  = 1'b0;
  localparam logic LEG_SECOND = 1'b1;

endpackage

// File: rtl/lock_scheduler_if.sv
// rtl/lock_scheduler_if.sv - request/pump/door bundle between operator panel and airlock scheduler.
interface lock_scheduler_if #(
  parameter int LEVEL_W = 4
);

  logic               req_sea;
  logic               req_dock;
  logic               passed;
  logic               grant_sea;
  logic               grant_dock;
  logic               fill;
  logic               drain;
  logic               outer_open;
  logic               inner_open;
  logic               busy;
  logic               timeout;
  logic [LEVEL_W-1:0] level;

  modport master (
    output req_sea, req_dock, passed,
    input  grant_sea, grant_dock, fill, drain, outer_open, inner_open, busy, timeout, level
  );

  modport slave (
    input  req_sea, req_dock, passed,
    output grant_sea, grant_dock, fill, drain, outer_open, inner_open, busy, timeout, level
  );

endinterface

// File: rtl/lock_rr_arbiter.sv
// rtl/lock_rr_arbiter.sv - two-way round-robin between sea and dock requests.
module lock_rr_arbiter
  import lock_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic req_sea,
  input  logic req_dock,
  output logic grant_sea,
  output logic grant_dock
);

  logic last_q;

  // On contention the side that was not served last wins.
  always_comb begin
    grant_sea  = en && req_sea  && (!req_dock || (last_q == SIDE_DOCK));
    grant_dock = en && req_dock && (!req_sea  || (last_q == SIDE_SEA));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= SIDE_DOCK;
    end else if (grant_sea) begin
      last_q <= SIDE_SEA;
    end else if (grant_dock) begin
      last_q <= SIDE_DOCK;
    end
  end

endmodule

// File: rtl/lock_scheduler.sv
// rtl/lock_scheduler.sv - airlock transit sequencer; LOCK_TIMEOUT_EN adds the door-open watchdog.
module lock_scheduler
  import lock_pkg::*;
#(
  parameter int LEVEL_W     = 4,
  parameter int LEVEL_MAX   = 15,
  parameter int STEP_CYC    = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clock,
  input  logic             reset,
  lock_scheduler_if.slave  bus
);

  localparam int                 STEP_W    = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [LEVEL_W-1:0] LVL_TOP   = LEVEL_W'(LEVEL_MAX);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_CYC - 1);

  state_t              state_q, state_n;
  logic [LEVEL_W-1:0]  level_q, level_n;
  logic [STEP_W-1:0]   step_q, step_n;
  logic                leg_q, leg_n;
  logic                grant_sea_q, grant_sea_n;
  logic                grant_dock_q, grant_dock_n;
  logic                arb_en, arb_sea, arb_dock;

`ifdef LOCK_TIMEOUT_EN
  localparam int               WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_n;
  logic            timeout_q, timeout_n;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  assign arb_en = (state_q == ST_IDLE);

  lock_rr_arbiter u_arb (
    .clock      (clock),
    .reset      (reset),
    .en         (arb_en),
    .req_sea    (bus.req_sea),
    .req_dock   (bus.req_dock),
    .grant_sea  (arb_sea),
    .grant_dock (arb_dock)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      step_q       <= '0;
      leg_q        <= LEG_FIRST;
      grant_sea_q  <= 1'b0;
      grant_dock_q <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_n;
      level_q      <= level_n;
      step_q       <= step_n;
      leg_q        <= leg_n;
      grant_sea_q  <= grant_sea_n;
      grant_dock_q <= grant_dock_n;
`ifdef LOCK_TIMEOUT_EN
      wd_q         <= wd_n;
      timeout_q    <= timeout_n;
`endif
    end
  end

  // Counters default to zero so every equalize/open state starts counting afresh.
  always_comb begin
    state_n      = state_q;
    level_n      = level_q;
    step_n       = '0;
    leg_n        = leg_q;
    grant_sea_n  = 1'b0;
    grant_dock_n = 1'b0;
`ifdef LOCK_TIMEOUT_EN
    wd_n         = '0;
    timeout_n    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        leg_n = LEG_FIRST;
        if (arb_sea) begin
          grant_sea_n = 1'b1;
          state_n     = ST_FILL;
        end else if (arb_dock) begin
          grant_dock_n = 1'b1;
          state_n      = ST_DRAIN;
        end
      end
      ST_FILL: begin
        if (level_q == LVL_TOP) begin
          state_n = ST_OPEN_OUT;
        end else if (step_q == STEP_LAST) begin
          level_n = level_q + LEVEL_W'(1);
        end else begin
          step_n = step_q + STEP_W'(1);
        end
      end
      ST_DRAIN: begin
        if (level_q == '0) begin
          state_n = ST_OPEN_IN;
        end else if (step_q == STEP_LAST) begin
          level_n = level_q - LEVEL_W'(1);
        end else begin
          step_n = step_q + STEP_W'(1);
        end
      end
      ST_OPEN_OUT, ST_OPEN_IN: begin
        if (bus.passed) begin
          if (leg_q == LEG_SECOND) begin
            state_n = ST_IDLE;
          end else begin
            leg_n   = LEG_SECOND;
            state_n = (state_q == ST_OPEN_OUT) ? ST_DRAIN : ST_FILL;
          end
        end
`ifdef LOCK_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          state_n   = ST_IDLE;
          timeout_n = 1'b1;
        end else begin
          wd_n = wd_q + WD_W'(1);
        end
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.grant_sea  = grant_sea_q;
  assign bus.grant_dock = grant_dock_q;
  assign bus.fill       = (state_q == ST_FILL)  && (level_q != LVL_TOP);
  assign bus.drain      = (state_q == ST_DRAIN) && (level_q != '0);
  assign bus.outer_open = (state_q == ST_OPEN_OUT);
  assign bus.inner_open = (state_q == ST_OPEN_IN);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.level      = level_q;
`ifdef LOCK_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_lock_scheduler.sv
// tb/tb_lock_scheduler.sv - randomized transit sequences against a transaction-level airlock model.
module tb_lock_scheduler;

  localparam int STEP = 4;
  localparam int MAX  = 15;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   ncmp  = 0;
  int   nerr  = 0;

  // Model state: chamber level and the side served last (0 = sea, 1 = dock).
  int   m_level = 0;
  bit   m_last  = 1'b1;

  lock_scheduler_if #(.LEVEL_W(4)) bus ();

  lock_scheduler #(
    .LEVEL_W     (4),
    .LEVEL_MAX   (MAX),
    .STEP_CYC    (STEP),
    .TIMEOUT_CYC (64)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic inv;
    @(negedge clock);
    inv = !(bus.fill && bus.drain) && !(bus.outer_open && bus.inner_open) &&
          !((bus.outer_open || bus.inner_open) && (bus.fill || bus.drain)) &&
          (!bus.outer_open || (bus.level == 4'(MAX))) && (!bus.inner_open || (bus.level == 4'd0));
    check("interlock", 32'(inv), 32'd1);
  endtask

  task automatic equalize(input bit to_full);
    int target, exp_pump, pump, wrong, total, lvl_p;
    bit door, pulsed;
    target   = to_full ? MAX : 0;
    exp_pump = (to_full ? (MAX - m_level) : m_level) * STEP;
    lvl_p    = $urandom_range(0, MAX);
    pulsed   = 1'b0;
    pump = 0; wrong = 0; total = 0;
    door = to_full ? bus.outer_open : bus.inner_open;
    while (!door && total < 2000) begin
      if (to_full ? bus.fill : bus.drain) pump++;
      if (to_full ? bus.drain : bus.fill) wrong++;
      if (total > 0 && (bus.grant_sea || bus.grant_dock)) wrong++;
      total++;
      if (!pulsed && (int'(bus.level) == lvl_p)) begin
        bus.passed   = 1'b1;
        bus.req_sea  = 1'($urandom_range(0, 1));
        bus.req_dock = 1'($urandom_range(0, 1));
        pulsed       = 1'b1;
      end
      step();
      bus.passed = 1'b0;
      door = to_full ? bus.outer_open : bus.inner_open;
    end
    check("eq_cycles", 32'(total), 32'(exp_pump + 1));
    check("eq_pump", 32'(pump), 32'(exp_pump));
    check("eq_stray", 32'(wrong), 32'd0);
    check("eq_level", 32'(bus.level), 32'(target));
    m_level = target;
  endtask

  task automatic door_phase(input bit outer, input bit last_leg);
    int w;
    w = $urandom_range(0, 10);
    repeat (w) step();
    check("door_held", 32'(outer ? bus.outer_open : bus.inner_open), 32'd1);
    bus.passed = 1'b1;
    step();
    bus.passed = 1'b0;
    check("door_closed", 32'(outer ? bus.outer_open : bus.inner_open), 32'd0);
    if (last_leg) check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit s, d, hold, side;
    int guard;
    bus.req_sea = 1'b0; bus.req_dock = 1'b0; bus.passed = 1'b0;

    repeat (3) @(negedge clock);
    check("reset_outputs", 32'({bus.grant_sea, bus.grant_dock, bus.fill, bus.drain, bus.outer_open,
                                bus.inner_open, bus.busy, bus.timeout, bus.level}), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("quiet_busy", 32'(bus.busy), 32'd0);
    end

    // Interrupt an arrival half way up and confirm the asynchronous clear.
    bus.req_sea = 1'b1;
    step();
    check("pre_reset_grant", 32'(bus.grant_sea), 32'd1);
    bus.req_sea = 1'b0;
    guard = 0;
    while (bus.level !== 4'd7 && guard < 200) begin
      step();
      guard++;
    end
    check("fill_to_7", 32'(bus.level), 32'd7);
    #2 reset = 1'b0;
    #1 check("async_reset", 32'({bus.grant_sea, bus.grant_dock, bus.fill, bus.drain, bus.outer_open,
                                 bus.inner_open, bus.busy, bus.timeout, bus.level}), 32'd0);
    @(negedge clock);
    reset   = 1'b1;
    m_level = 0;
    m_last  = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (i < 3) begin
        s = 1'b1; d = 1'b1; hold = 1'b1;
      end else begin
        s    = 1'($urandom_range(0, 1));
        d    = s ? 1'($urandom_range(0, 1)) : 1'b1;
        hold = 1'($urandom_range(0, 1));
      end
      side   = (s && d) ? ~m_last : (s ? 1'b0 : 1'b1);
      m_last = side;
      bus.req_sea  = s;
      bus.req_dock = d;
      step();
      check("grant_sea", 32'(bus.grant_sea), 32'(side == 1'b0));
      check("grant_dock", 32'(bus.grant_dock), 32'(side == 1'b1));
      check("busy_rise", 32'(bus.busy), 32'd1);
      if (!hold) begin
        bus.req_sea  = 1'b0;
        bus.req_dock = 1'b0;
      end
      if (side == 1'b0) begin
        equalize(1'b1); door_phase(1'b1, 1'b0);
        equalize(1'b0); door_phase(1'b0, 1'b1);
      end else begin
        equalize(1'b0); door_phase(1'b0, 1'b0);
        equalize(1'b1); door_phase(1'b1, 1'b1);
      end
    end

    // Leave the outer door open with nobody passing.
    bus.req_sea  = 1'b1;
    bus.req_dock = 1'b0;
    step();
    check("wd_grant", 32'(bus.grant_sea), 32'd1);
    bus.req_sea = 1'b0;
    m_last      = 1'b0;
    equalize(1'b1);
`ifdef LOCK_TIMEOUT_EN
    repeat (63) step();
    check("wd_still_open", 32'(bus.outer_open), 32'd1);
    step();
    check("wd_timeout", 32'(bus.timeout), 32'd1);
    check("wd_door", 32'(bus.outer_open), 32'd0);
    check("wd_idle", 32'(bus.busy), 32'd0);
    check("wd_level", 32'(bus.level), 32'(MAX));
`else
    repeat (1000) step();
    check("no_wd_open", 32'(bus.outer_open), 32'd1);
    check("no_wd_timeout", 32'(bus.timeout), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/lock_scheduler.md
# lock_scheduler

Sequencing controller for the bathysphere airlock chamber. It accepts transit requests from the sea side (arrival) and the dock side (departure), arbitrates them round-robin, and drives chamber fill/drain and door-open commands. Each accepted request runs one complete transit: equalize, open the first door, wait for passage, re-equalize, open the second door, wait for passage. It sits between the switch/key inputs and the interlock display logic, replacing manual fill/drain/port control.

## Interface
Parameters:
- `LEVEL_W`, 4: width of the chamber water-level count.
- `LEVEL_MAX`, 15: flooded level, equal to sea pressure. Level 0 is dry, equal to dock pressure.
- `STEP_CYC`, 4: clock cycles per one-level change during fill or drain. Must be ≥1.
- `TIMEOUT_CYC`, 64: door-open watchdog limit. Used only with `LOCK_TIMEOUT_EN`.

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-low reset. Asserted when 0.
- `req_sea` in 1: level request, arrival from the sea side.
- `req_dock` in 1: level request, departure from the dock side.
- `passed` in 1: occupant has cleared the currently open door. Single-cycle pulse.
- `grant_sea`, `grant_dock` out 1: one-cycle pulse when a request is accepted.
- `fill`, `drain` out 1: chamber pump commands. Never both high.
- `outer_open`, `inner_open` out 1: door commands. Never both high.
- `busy` out 1: high whenever state ≠ IDLE.
- `level` out `LEVEL_W`: current chamber level.
- `timeout` out 1: one-cycle pulse when the watchdog fires. Tied 0 without the macro.

## Operation
- States: IDLE, FILL, DRAIN, OPEN_OUT, OPEN_IN. A `leg` bit (0 = first door, 1 = second door) qualifies each state.
- **IDLE**
  - Samples `req_sea` and `req_dock`.
  - If exactly one is high, that side is granted.
  - If both are high, the side not served last is granted. After reset, sea wins first.
  - On grant: pulse `grant_*`, set leg=0, and move to the transit start state on the next edge.
- **Arrival (sea)**: FILL → OPEN_OUT → DRAIN → OPEN_IN → IDLE.
- **Departure (dock)**: DRAIN → OPEN_IN → FILL → OPEN_OUT → IDLE.
- **FILL**
  - `fill` = (level ≠ LEVEL_MAX).
  - `level` increments by 1 every `STEP_CYC` cycles. The step counter clears on state entry.
  - In the first cycle with level == LEVEL_MAX, move to OPEN_OUT.
  - If already at LEVEL_MAX on entry, the state is held for exactly one cycle.
- **DRAIN**: mirror of FILL, decrementing to 0, then move to OPEN_IN.
- **Level arithmetic**: saturating. Level never wraps past 0 or LEVEL_MAX.
- **OPEN_OUT / OPEN_IN**
  - The corresponding door output is high.
  - On `passed`: close the door the same edge. If leg=0, set leg=1 and go to the opposite equalize state. If leg=1, go to IDLE.
- **Interlock invariants**
  - `outer_open` only when level == LEVEL_MAX.
  - `inner_open` only when level == 0.
  - A door is never open while a pump is on.
- `passed` outside the OPEN states is ignored.
- Requests outside IDLE are ignored, not queued. A level still high on return to IDLE is arbitrated normally.

## Timing
- Reset values: state IDLE, level 0, leg 0, last-served = dock, all outputs 0.
- Reset mid-operation: all outputs drop to 0 immediately and asynchronously. Level returns to 0.
- Grant latency: a request high at edge N gives `grant_*` high in cycle N+1. `busy` rises at N+1.
- Full equalize: LEVEL_MAX·STEP_CYC cycles of pump activity plus one settle cycle. With defaults, 60 + 1 cycles.
- Door close latency: a `passed` sampled at edge N drops the door output after edge N.

## Configuration
- `LOCK_TIMEOUT_EN` defined:
  - The watchdog counts cycles in OPEN_*. Its count clears on state entry.
  - At `TIMEOUT_CYC` cycles without `passed`: close the door, pulse `timeout`, go to IDLE.
  - The level is left as is. A leg=1 timeout leaves the occupant in the chamber; the next transit handles it.
- Undefined: no counter is built, `timeout` is constant 0, and doors stay open indefinitely.

## Structure
- `lock_pkg`: state enum, `SIDE_SEA`/`SIDE_DOCK` constants, leg encoding.
- Sub-module `lock_rr_arbiter`: 2-way round-robin with a last-served register. Its grant enable is asserted only in IDLE.
- The step counter and watchdog counter live in `lock_scheduler`.

## Test plan
- Reset: hold `reset`=0 → all outputs 0, level 0. Release, no requests → `busy` stays 0.
- Arrival with defaults:
  - `req_sea`=1 → `grant_sea` next cycle.
  - `fill` high for 60 cycles, level 0→15, then `outer_open`.
  - `passed` → `drain` for 60 cycles, then `inner_open`.
  - `passed` → IDLE.
- Contention: `req_sea`=`req_dock`=1 held → grants in order sea, dock, sea. A departure starts with DRAIN held exactly one cycle at level 0.
- Ignored inputs:
  - `passed` pulsed during FILL at level 7 → no change.
  - `req_dock` raised mid-arrival → no grant until IDLE.
- Reset mid-FILL at level 7 → outputs 0 immediately. Post-reset `req_sea` fills from 0.
- Timeout (macro defined): 64 cycles in OPEN_OUT without `passed` → `timeout` pulse, `outer_open` drops, IDLE, level 15. Without the macro, `outer_open` is still high after 1000 cycles.
